aes_128_stream_if: RTL and testbench

Upstream/downstream wrapper stage for the fixed-latency, non-stallable aes_128 pipeline core. It accepts plaintext/key pairs on a valid/ready handshake and drives them into the core's state/key inputs. It tracks in-flight blocks with a tag shift register, captures core results into an output FIFO, and returns them on a valid/ready handshake. Credit-based admission ensures no result is ever dropped, even though the core cannot be stalled.

---
 rtl/aes_128_stream_if.sv | 118 +++++++++++
 tb/tb_aes_128_stream_if.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_stream_if.sv
// Valid/ready wrapper around the fixed-latency, non-stallable aes_128 pipeline core.
// Optional performance counters are enabled with the AES_STREAM_PERF_EN macro.
`timescale 1ns/1ps
module aes_128_stream_if #(
   parameter int unsigned LATENCY    = 21,
   parameter int unsigned FIFO_DEPTH = 32,
   parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_state,
   input  logic [127:0]     in_key,
   output logic [127:0]     core_state,
   output logic [127:0]     core_key,
   input  logic [127:0]     core_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic [CNT_W-1:0] inflight,
   output logic [CNT_W-1:0] fifo_count
`ifdef AES_STREAM_PERF_EN
   ,
   output logic [31:0]      issued_cnt,
   output logic [31:0]      done_cnt,
   output logic [31:0]      stall_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   logic [LATENCY-1:0] tag_q, tag_d;
   logic [CNT_W-1:0]   inflight_q, inflight_d;
   logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [127:0]       mem [FIFO_DEPTH];
   logic [CNT_W:0]     occupancy;
   logic               issue, write, pop;

   assign core_state = in_state;
   assign core_key   = in_key;

   // Credits cover both in-flight and buffered blocks, so every core result has a FIFO slot.
   assign occupancy  = {1'b0, inflight_q} + {1'b0, fifo_count_q};
   assign in_ready   = !rst && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
   assign issue      = in_valid && in_ready;
   assign write      = tag_q[LATENCY-1];
   assign out_valid  = (fifo_count_q != '0);
   assign pop        = out_valid && out_ready;
   assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
   assign inflight   = inflight_q;
   assign fifo_count = fifo_count_q;

   always_comb begin
      tag_d        = {tag_q[LATENCY-2:0], issue};
      inflight_d   = inflight_q + CNT_W'(issue) - CNT_W'(write);
      fifo_count_d = fifo_count_q + CNT_W'(write) - CNT_W'(pop);
      wr_ptr_d     = write ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q        <= '0;
         inflight_q   <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         tag_q        <= tag_d;
         inflight_q   <= inflight_d;
         fifo_count_q <= fifo_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only observed while fifo_count is non-zero.
   always_ff @(posedge clk) begin
      if (write) begin
         mem[wr_ptr_q] <= core_out;
      end
   end

   write_into_full_a: assert property (@(posedge clk) disable iff (rst)
      !(write && (fifo_count_q == CNT_W'(FIFO_DEPTH))));

`ifdef AES_STREAM_PERF_EN
   logic [31:0] issued_cnt_q, issued_cnt_d;
   logic [31:0] done_cnt_q, done_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      issued_cnt_d = issued_cnt_q + 32'(issue);
      done_cnt_d   = done_cnt_q + 32'(pop);
      stall_cnt_d  = stall_cnt_q + 32'(in_valid && !in_ready);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued_cnt_q <= '0;
         done_cnt_q   <= '0;
         stall_cnt_q  <= '0;
      end else begin
         issued_cnt_q <= issued_cnt_d;
         done_cnt_q   <= done_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign issued_cnt = issued_cnt_q;
   assign done_cnt   = done_cnt_q;
   assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_aes_128_stream_if.sv
// Bench for aes_128_stream_if: fixed-latency core stand-in, timestamp queue model, directed tests.
// Perf counter checks are compiled in when AES_STREAM_PERF_EN is defined.
`timescale 1ns/1ps
module tb_aes_128_stream_if;

   localparam int unsigned LAT   = 21;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned CW    = 6;

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [127:0]  in_state = '0;
   logic [127:0]  in_key = '0;
   logic [127:0]  core_state, core_key, core_out;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [127:0]  out_data;
   logic [CW-1:0] inflight, fifo_count;
`ifdef AES_STREAM_PERF_EN
   logic [31:0]   issued_cnt, done_cnt, stall_cnt;
`endif

   int unsigned total = 0;
   int unsigned bad = 0;

   aes_128_stream_if dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_state   (in_state),
      .in_key     (in_key),
      .core_state (core_state),
      .core_key   (core_key),
      .core_out   (core_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .inflight   (inflight),
      .fifo_count (fifo_count)
`ifdef AES_STREAM_PERF_EN
      ,
      .issued_cnt (issued_cnt),
      .done_cnt   (done_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in cipher: real AES for the FIPS-197 vector, a cheap bijective mix otherwise.
   function automatic logic [127:0] cipher(input logic [127:0] s, input logic [127:0] k);
      if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
      return s ^ {k[63:0], k[127:64]} ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
   endfunction

   // Core: captures every edge, result visible LAT-1 edges after capture.
   logic [127:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= cipher(core_state, core_key);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign core_out = pipe[LAT-1];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Model: every unpopped block with the edge number at which it lands in the FIFO.
   typedef struct {
      logic [127:0] d;
      int unsigned  wt;
   } ent_t;
   ent_t        mq[$];
   int unsigned now = 0;
   int unsigned m_iss = 0, m_done = 0, m_stall = 0;

   function automatic int unsigned m_landed();
      int unsigned c = 0;
      foreach (mq[i]) if (mq[i].wt <= now) c++;
      return c;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      int unsigned nl;
      logic        m_pop, m_iss_now;
      if (rst) begin
         mq.delete();
         m_iss   = 0;
         m_done  = 0;
         m_stall = 0;
      end else begin
         nl        = m_landed();
         m_pop     = (nl > 0) && out_ready;
         m_iss_now = in_valid && (mq.size() < DEPTH);
         if (in_valid && !m_iss_now) m_stall++;
         now++;
         if (m_pop) begin
            void'(mq.pop_front());
            m_done++;
         end
         if (m_iss_now) begin
            mq.push_back('{d: cipher(in_state, in_key), wt: now + LAT});
            m_iss++;
         end
      end
   end

   always @(negedge clk) begin : compare
      int unsigned cl;
      cl = m_landed();
      chk("in_ready", 128'(in_ready), 128'(!rst && (mq.size() < DEPTH)));
      chk("out_valid", 128'(out_valid), 128'(cl > 0));
      chk("fifo_count", 128'(fifo_count), 128'(cl));
      chk("inflight", 128'(inflight), 128'(mq.size() - cl));
      if (cl > 0) chk("out_data", out_data, mq[0].d);
      else if (rst) chk("out_data_rst", out_data, '0);
`ifdef AES_STREAM_PERF_EN
      chk("issued_cnt", 128'(issued_cnt), 128'(m_iss));
      chk("done_cnt", 128'(done_cnt), 128'(m_done));
      chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic new_data();
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic drain();
      int unsigned n = 0;
      out_ready = 1'b1;
      while ((out_valid || inflight != '0) && n < 300) begin
         step();
         n++;
      end
      chk("drain_bound", 128'(n < 300), 128'(1));
      out_ready = 1'b0;
   endtask

   int unsigned n, acc, pops, first_pop, last_pop, cyc;

   initial begin
      // Reset
      #2;
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_counts", 128'({inflight, fifo_count}), 128'(0));
      step();
      step();
      rst = 1'b0;
      step();

      // FIPS-197 vector, single issue
      in_valid = 1'b1;
      in_state = FIPS_PT;
      in_key   = FIPS_KEY;
      step();
      in_valid = 1'b0;
      new_data();
      n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      chk("fips_latency", 128'(n), 128'(LAT));
      chk("fips_ct", out_data, FIPS_CT);
      chk("fips_inflight", 128'(inflight), 128'(0));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("fips_popped", 128'(out_valid), 128'(0));

      // 64 back-to-back blocks with out_ready held high
      out_ready = 1'b1;
      pops = 0;
      cyc = 0;
      first_pop = 0;
      last_pop = 0;
      for (int i = 0; i < 64; i++) begin
         in_valid = 1'b1;
         new_data();
         chk("b2b_ready", 128'(in_ready), 128'(1));
         if (out_valid) begin
            if (pops == 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      n = 0;
      while ((out_valid || inflight != '0) && n < 100) begin
         if (out_valid) begin
            last_pop = cyc;
            pops++;
         end
         step();
         cyc++;
         n++;
      end
      chk("b2b_pops", 128'(pops), 128'(64));
      chk("b2b_contiguous", 128'(last_pop - first_pop + 1), 128'(64));
      out_ready = 1'b0;

      // Fill with out_ready low
      acc = 0;
      in_valid = 1'b1;
      repeat (80) begin
         if (in_ready) acc++;
         step();
         new_data();
      end
      chk("fill_accepted", 128'(acc), 128'(DEPTH));
      chk("fill_fifo_count", 128'(fifo_count), 128'(DEPTH));
      chk("fill_inflight", 128'(inflight), 128'(0));
      chk("fill_in_ready", 128'(in_ready), 128'(0));

      // One-cycle pop from full, then exactly one new issue
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("pulse_in_ready", 128'(in_ready), 128'(1));
      step();
      new_data();
      chk("pulse_refull", 128'(in_ready), 128'(0));
      chk("pulse_inflight", 128'(inflight), 128'(1));
      in_valid = 1'b0;
      repeat (LAT + 2) step();
      chk("pulse_fifo_count", 128'(fifo_count), 128'(DEPTH));
      drain();

      // Reset with 10 blocks in flight and 5 in the FIFO
      in_valid = 1'b1;
      repeat (5) begin
         step();
         new_data();
      end
      in_valid = 1'b0;
      repeat (LAT + 1) step();
      chk("pre_rst_fifo5", 128'(fifo_count), 128'(5));
      in_valid = 1'b1;
      repeat (10) begin
         step();
         new_data();
      end
      in_valid = 1'b0;
      step();
      step();
      chk("pre_rst_inflight", 128'(inflight), 128'(10));
      chk("pre_rst_fifo", 128'(fifo_count), 128'(5));
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_inflight", 128'(inflight), 128'(0));
      chk("mid_rst_fifo", 128'(fifo_count), 128'(0));
      chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
      step();
      step();
      rst = 1'b0;
      repeat (2 * LAT) begin
         chk("post_rst_no_stale", 128'({out_valid, inflight, fifo_count}), 128'(0));
         step();
      end

      // Fill, 5 stall cycles, then drain everything
      acc = 0;
      n = 0;
      in_valid = 1'b1;
      while (acc < DEPTH && n < 100) begin
         if (in_ready) acc++;
         step();
         new_data();
         n++;
      end
      chk("perf_accepted", 128'(acc), 128'(DEPTH));
      repeat (5) step();
      in_valid = 1'b0;
      repeat (LAT + 2) step();
      drain();
`ifdef AES_STREAM_PERF_EN
      chk("perf_issued", 128'(issued_cnt), 128'(32));
      chk("perf_done", 128'(done_cnt), 128'(32));
      chk("perf_stall", 128'(stall_cnt), 128'(5));
`endif
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
